ip_megarom_ex: RTL
==================

// Module: ip_megarom_ex
// PURPOSE
//  Parametrised MSX MegaROM mapper, successor of the fixed 22-bit mapper.
//  - Decodes MSX-50BUS memory reads and bank-register writes for 8 mapper types.
//  - Maps each 8KB CPU page to a RAM address of configurable width.
//  - Adds a ROM-size wrap mask, a base offset, a busy/rdata_en read FSM and a
//    read timeout. Sits between the bus slot decoder and the SDRAM/PSRAM arbiter.
// PARAMETERS
//  RAM_AW    22  RAM address width; bank width BANK_W = RAM_AW-13 (>=8, <=12).
//  ROM_BASE  0   Offset added to the mapped address, in 8KB units (BANK_W bits).
//  TIMEOUT   64  Cycles from rd assertion before a read is abandoned (>=4).
// PORTS
//  clk             in   1        system clock (21.477MHz)
//  n_reset         in   1        asynchronous reset, active-low
//  mode            in   3        0 ASC8, 1 ASC16, 2 Normal, 3 Kon4, 4 SCC, 5 SCC-I, 6 Generic8, 7 Generic16
//  rom_mask        in   BANK_W   bank AND-mask (ROM size-1 in 8KB units) for mirroring
//  bus_address     in   16       CPU address, valid in strobe cycle
//  bus_io_cs       out  1        constant 0
//  bus_memory_cs   out  1        constant 1
//  bus_read_ready  out  1        1-cycle pulse: bus_read_data valid
//  bus_read_data   out  8        read data, held until next read completes
//  bus_write_data  in   8        write data, valid in strobe cycle
//  bus_read        in   1        1-cycle read strobe
//  bus_write       in   1        1-cycle write strobe
//  bus_io          in   1        I/O qualifier (ignored: no I/O decode)
//  bus_memory      in   1        memory qualifier
//  rd              out  1        RAM read request
//  wr              out  1        RAM write request (constant 0, reserved)
//  busy            in   1        RAM cannot accept request this cycle
//  address         out  RAM_AW   RAM address
//  wdata           out  8        constant 0 (reserved)
//  rdata           in   8        RAM read data
//  rdata_en        in   1        rdata valid
// BEHAVIOUR
//  Reset values
//  - rd=0, bus_read_ready=0, bus_read_data=0, address=0, FSM=IDLE.
//  - Banks: ASC8/ASC16/Generic16 all 0; every other mode bank0..3 = 0,1,2,3.
//  - mode is static; it is sampled only by reset for initial bank values.
//  Page index
//  - idx = {~A[14], A[13]}: 0000/8000 -> bank2, 2000/A000 -> bank3,
//    4000/C000 -> bank0, 6000/E000 -> bank1.
//  Register writes (bus_write & bus_memory), effective the next cycle
//  - ASC8:  6000-7FFF, bank[A[12:11]].
//  - ASC16: 6000-67FF -> pair0, 7000-77FF -> pair1; 6800-6FFF/7800-7FFF ignored.
//  - Normal: writes ignored.
//  - Kon4: 6000-7FFF/8000-9FFF/A000-BFFF -> bank1/2/3; bank0 fixed 0.
//  - SCC/SCC-I: 5000-57FF/7000-77FF/9000-97FF/B000-B7FF -> bank0..3
//    (sound/RAM functions out of scope).
//  - Generic8: 4000-BFFF, bank[idx]. Generic16: 4000-7FFF pair0, 8000-BFFF pair1.
//  - Value width: bank value is bus_write_data zero-extended to BANK_W.
//  16KB modes (ASC16, Generic16)
//  - Pair p (p=0 for idx 0,1; p=1 for idx 2,3) yields effective bank {reg_p, A[13]}.
//    Stored reg is BANK_W-1 bits; upper bits truncated.
//  Address
//  - address = ({ebank & rom_mask} + ROM_BASE) * 8192 + A[12:0], mod 2^RAM_AW.
//  Read FSM
//  - IDLE: on bus_read & bus_memory, latch A and the computed address, set rd=1 -> REQ.
//  - REQ: rd held while busy=1; first cycle with busy=0 accepts -> rd=0 next cycle, WAIT.
//  - WAIT: on rdata_en, capture rdata into bus_read_data -> DONE.
//  - DONE: bus_read_ready=1 for exactly one cycle -> IDLE.
//  - Latency with busy=0 and a 1-cycle RAM: bus_read_ready 3 cycles after the strobe.
//  - Timeout: counter starts at rd rise. If it reaches TIMEOUT in REQ/WAIT:
//    rd=0, bus_read_data=FFh, go to DONE.
//  Boundary conditions
//  - bus_read while not IDLE: dropped.
//  - Bank write during an in-flight read: no effect on that read's latched address.
//  - Simultaneous bus_read and bus_write: write applies, read ignored.
//  - rdata_en in IDLE/REQ: ignored.
//  - Reset mid-read: FSM to IDLE, rd=0 immediately, no ready pulse.
// TESTING
//  1. ASC8: write 6000=12,6800=34,7000=56,7800=78; read 0000..FFFF
//     -> address[20:13] 56,78,12,34,56,78,12,34 per 8KB page; [12:0]=A[12:0].
//  2. ASC16: write 67FF=56,77FF=78, then 6FFF=44,7FFF=55
//     -> 4000 bank AC, 6000 AD, 8000 F0, A000 F1 (invalid writes ignored).
//  3. Kon4 after reset: write 4000=09, 6000=05 -> 4000 reads bank 0, 6000 bank 5,
//     8000 bank 2.
//  4. Generic8, rom_mask=0F, ROM_BASE=10h: write 8000=23 -> 8000 read address = (03+10h)*8192.
//  5. busy=1 for 5 cycles: rd held 5 cycles then drops; ready pulses once with rdata=A5.
//  6. rdata_en never asserted -> ready after TIMEOUT cycles with FFh;
//     n_reset pulsed mid-REQ -> rd=0, no ready.

Source files
------------

// File: rtl/ip_megarom_ex.sv
// MSX MegaROM mapper: decodes bank-register writes for eight mapper types and turns
// CPU memory reads into RAM read requests via a busy/rdata_en handshake with timeout.
module ip_megarom_ex #(
  parameter int  RAM_AW   = 22,
  parameter int  ROM_BASE = 0,
  parameter int  TIMEOUT  = 64,
  localparam int BANK_W   = RAM_AW - 13
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [2:0]        mode,
  input  logic [BANK_W-1:0] rom_mask,
  input  logic [15:0]       bus_address,
  output logic              bus_io_cs,
  output logic              bus_memory_cs,
  output logic              bus_read_ready,
  output logic [7:0]        bus_read_data,
  input  logic [7:0]        bus_write_data,
  input  logic              bus_read,
  input  logic              bus_write,
  input  logic              bus_io,
  input  logic              bus_memory,
  output logic              rd,
  output logic              wr,
  input  logic              busy,
  output logic [RAM_AW-1:0] address,
  output logic [7:0]        wdata,
  input  logic [7:0]        rdata,
  input  logic              rdata_en
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    M_ASC8, M_ASC16, M_NORMAL, M_KON4, M_SCC, M_SCCI, M_GEN8, M_GEN16
  } mode_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  mode_t             mode_e;
  logic              is_16k;
  logic              zero_rst;
  logic [1:0]        idx;
  logic [BANK_W-1:0] bank_q [4];
  logic [3:0]        bank_we;
  logic [BANK_W-1:0] ebank;
  logic [BANK_W-1:0] map_bank;
  logic [RAM_AW-1:0] map_addr;

  state_t            state_q, state_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start;
  logic              timed_out;
  logic              unused_io;

  assign mode_e    = mode_t'(mode);
  assign is_16k    = (mode_e == M_ASC16) || (mode_e == M_GEN16);
  assign zero_rst  = (mode_e == M_ASC8) || is_16k;
  assign idx       = {~bus_address[14], bus_address[13]};
  assign unused_io = bus_io;

  // Bank-register write decode; in 16KB modes bank_q[0]/bank_q[1] hold the pair registers.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    bank_we = '0;
    if (bus_write && bus_memory) begin
      case (mode_e)
        M_ASC8:
          if (bus_address[15:13] == 3'b011) bank_we[bus_address[12:11]] = 1'b1;
        M_ASC16:
          if (bus_address[15:11] == 5'b01100)      bank_we[0] = 1'b1;
          else if (bus_address[15:11] == 5'b01110) bank_we[1] = 1'b1;
        M_KON4:
          case (bus_address[15:13])
            3'b011:  bank_we[1] = 1'b1;
            3'b100:  bank_we[2] = 1'b1;
            3'b101:  bank_we[3] = 1'b1;
            default: ;
          endcase
        M_SCC, M_SCCI:
          if (bus_address[12:11] == 2'b10 && (bus_address[15] ^ bus_address[14]))
            bank_we[{bus_address[15], bus_address[13]}] = 1'b1;
        M_GEN8:
          if (bus_address[15] ^ bus_address[14]) bank_we[idx] = 1'b1;
        M_GEN16:
          if (bus_address[15:14] == 2'b01)      bank_we[0] = 1'b1;
          else if (bus_address[15:14] == 2'b10) bank_we[1] = 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the four bank registers are plain flops, not RAM, so they take a reset value like any other state.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < 4; i++) bank_q[i] <= zero_rst ? '0 : BANK_W'(i);
    end else begin
      for (int i = 0; i < 4; i++)
        if (bank_we[i]) bank_q[i] <= BANK_W'(bus_write_data);
    end
  end

  always_comb begin
    if (is_16k) ebank = {bank_q[{1'b0, idx[1]}][BANK_W-2:0], bus_address[13]};
    else        ebank = bank_q[idx];
    map_bank = (ebank & rom_mask) + BANK_W'(ROM_BASE);
  end

  assign map_addr  = {map_bank, bus_address[12:0]};
  assign start     = bus_read && bus_memory && !bus_write;
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:
        if (start) begin
          state_d = S_REQ;
          addr_d  = map_addr;
          cnt_d   = '0;
        end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timed_out) begin
          state_d = S_DONE;
          data_d  = 8'hFF;
        end else if (!busy) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Real data wins over a timeout landing on the same cycle.
        if (rdata_en) begin
          state_d = S_DONE;
          data_d  = rdata;
        end else if (timed_out) begin
          state_d = S_DONE;
          data_d  = 8'hFF;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd             = (state_q == S_REQ);
    bus_read_ready = (state_q == S_DONE);
  end

  assign bus_io_cs     = 1'b0;
  assign bus_memory_cs = 1'b1;
  assign wr            = 1'b0;
  assign wdata         = 8'h00;
  assign address       = addr_q;
  assign bus_read_data = data_q;

endmodule
